// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: round-robin between the ALU (req0) and
// load (req1) writeback paths, a one-entry write stage driving the write
// port, and forwarding of the staged write onto both read ports.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_SELECT_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        req0_valid,
    input  logic [REG_SELECT_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]       req0_data,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [REG_SELECT_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]       req1_data,
    output logic                        req1_ready,
    output logic                        RegWrite,
    output logic [REG_SELECT_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0]       write_data,
    input  logic [REG_SELECT_WIDTH-1:0] read_sel_1,
    input  logic [REG_SELECT_WIDTH-1:0] read_sel_2,
    input  logic [DATA_WIDTH-1:0]       rf_read_data_1,
    input  logic [DATA_WIDTH-1:0]       rf_read_data_2,
    output logic [DATA_WIDTH-1:0]       read_data_1,
    output logic [DATA_WIDTH-1:0]       read_data_2
);

    typedef struct packed {
        logic                        valid;
        logic [REG_SELECT_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]       data;
    } stage_t;

    stage_t stage_q, stage_d;
    // last_grant_q = 1 means req1 won the most recent grant
    logic   last_grant_q, last_grant_d;
    logic   grant0, grant1;

    // Grant: single requester wins outright; on contention the one not granted last wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!stall) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next stage contents: the winner, or an all-zero empty entry
    always_comb begin
        stage_d      = '0;
        last_grant_d = last_grant_q;
        if (grant0) begin
            stage_d.valid = 1'b1;
            stage_d.addr  = req0_addr;
            stage_d.data  = req0_data;
            last_grant_d  = 1'b0;
        end else if (grant1) begin
            stage_d.valid = 1'b1;
            stage_d.addr  = req1_addr;
            stage_d.data  = req1_data;
            last_grant_d  = 1'b1;
        end
    end

    // Write stage reloads every cycle; arbiter history only moves on a grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            stage_q      <= stage_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign RegWrite      = stage_q.valid;
    assign write_address = stage_q.addr;
    assign write_data    = stage_q.data;

    // Bypass the staged write so reads during the write cycle see new data
    always_comb begin
        read_data_1 = rf_read_data_1;
        read_data_2 = rf_read_data_2;
        if (stage_q.valid && (read_sel_1 == stage_q.addr)) read_data_1 = stage_q.data;
        if (stage_q.valid && (read_sel_2 == stage_q.addr)) read_data_2 = stage_q.data;
    end

endmodule
